// File: rtl/clkfwd_pkg.sv
// ============================================================================
// Module   : clkfwd_pkg
// Purpose  : Shared types and constants for the forwarded-clock generator
//            (state encoding, default field widths, idle output level).
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package clkfwd_pkg;

   // Forwarded-clock FSM states.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      STOP = 2'd2
   } state_t;

   // Default width of the half-period divider field.
   localparam int DEF_DIV_WIDTH   = 8;
   // Default width of the burst-length field (burst build only).
   localparam int DEF_BURST_WIDTH = 16;

   // Level of the positive leg while the clock is not running.
   localparam logic IDLE_LEVEL = 1'b0;

endpackage : clkfwd_pkg

`default_nettype wire

// File: rtl/ogdsbuf_tech.sv
// ============================================================================
// Module   : ogdsbuf_tech
// Purpose  : Technology wrapper for the differential clock output buffer.
//            Default build is an inferred pass-through of both registered
//            legs; defining CLKFWD_TECH_KC705 selects the KC705 differential
//            output primitive. Purely combinational.
// Ports    : i_clk_p  - registered positive leg
//            i_clk_n  - registered negative leg (complement)
//            o_pad_p  - positive output pad
//            o_pad_n  - negative output pad
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ogdsbuf_tech (
   input  logic i_clk_p,
   input  logic i_clk_n,
   output logic o_pad_p,
   output logic o_pad_n
);

`ifdef CLKFWD_TECH_KC705
   // The primitive derives its complementary pad internally from I; the
   // separately registered n leg is only consumed by the inferred model.
   OBUFDS #(
      .IOSTANDARD ("LVDS_25")
   ) u_obufds (
      .I  (i_clk_p),
      .O  (o_pad_p),
      .OB (o_pad_n)
   );
`else
   assign o_pad_p = i_clk_p;
   assign o_pad_n = i_clk_n;
`endif

endmodule : ogdsbuf_tech

`default_nettype wire

// File: rtl/ogdsclk_fwd.sv
// ============================================================================
// Module   : ogdsclk_fwd
// Purpose  : Forwarded-clock generator. Divides i_clk by an integer
//            half-period (i_div+1), starts and stops glitch-free (the high
//            phase is never shortened) and drives matched registered p/n legs
//            into a differential output buffer.
// Config   : CLKFWD_BURST_EN - adds i_burst; the clock stops by itself after
//            the requested number of high pulses (0 = unlimited) and a new
//            start then needs i_ena to have been seen low.
// Ports    : i_clk     - system clock, all logic rising-edge
//            i_rst     - synchronous reset, active-high
//            i_ena     - request forwarded clock running
//            i_div     - half-period minus one, sampled at start only
//            i_burst   - pulse count, 0 = unlimited (CLKFWD_BURST_EN only)
//            o_clk_p   - forwarded clock, positive leg
//            o_clk_n   - forwarded clock, negative leg
//            o_running - FSM in RUN
//            o_busy    - FSM not in IDLE
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ogdsclk_fwd
   import clkfwd_pkg::*;
#(
   parameter int DIV_WIDTH   = DEF_DIV_WIDTH
`ifdef CLKFWD_BURST_EN
   ,
   parameter int BURST_WIDTH = DEF_BURST_WIDTH
`endif
) (
   input  logic                   i_clk,
   input  logic                   i_rst,
   input  logic                   i_ena,
   input  logic [DIV_WIDTH-1:0]   i_div,
`ifdef CLKFWD_BURST_EN
   input  logic [BURST_WIDTH-1:0] i_burst,
`endif
   output logic                   o_clk_p,
   output logic                   o_clk_n,
   output logic                   o_running,
   output logic                   o_busy
);

   state_t               state;
   logic                 level;      // logical clock level driving the FSM
   logic [DIV_WIDTH-1:0] cnt;        // position inside the current half-period
   logic [DIV_WIDTH-1:0] div_r;      // half-period length latched at start
   logic                 leg_p;      // registered positive leg
   logic                 leg_n;      // registered negative leg
   logic                 running;
   logic                 busy;

   logic                 toggle;     // last cycle of the current half-period
   logic                 start;      // IDLE -> RUN request
   logic                 self_stop;  // burst exhausted on this falling toggle

   assign toggle = (cnt == div_r);

`ifdef CLKFWD_BURST_EN
   logic [BURST_WIDTH-1:0] rem;      // remaining high pulses, 0 = unlimited
   logic                   armed;    // i_ena seen low since last self-stop

   assign start     = i_ena & armed;
   assign self_stop = (state == RUN) & i_ena & toggle & level &
                      (rem == BURST_WIDTH'(1));

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         rem   <= '0;
         armed <= 1'b1;
      end else begin
         // A low i_ena always re-arms; a self-stop disarms until then.
         if (!i_ena) begin
            armed <= 1'b1;
         end else if (self_stop) begin
            armed <= 1'b0;
         end

         if (state == IDLE) begin
            if (start) begin
               rem <= i_burst;
            end
         end else if ((state == RUN) && toggle && level && (rem != '0)) begin
            rem <= rem - BURST_WIDTH'(1);
         end
      end
   end
`else
   assign start     = i_ena;
   assign self_stop = 1'b0;
`endif

   // Single FSM process. Output registers are written in the same branches
   // as state/level so that the p/n legs carry the new level on the same
   // edge; later assignments in a branch override earlier ones.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state   <= IDLE;
         level   <= IDLE_LEVEL;
         cnt     <= '0;
         div_r   <= '0;
         leg_p   <= IDLE_LEVEL;
         leg_n   <= ~IDLE_LEVEL;
         running <= 1'b0;
         busy    <= 1'b0;
      end else begin
         cnt <= cnt + DIV_WIDTH'(1);

         case (state)
            IDLE: begin
               cnt <= '0;
               if (start) begin
                  state   <= RUN;
                  level   <= 1'b1;
                  div_r   <= i_div;
                  leg_p   <= 1'b1;
                  leg_n   <= 1'b0;
                  running <= 1'b1;
                  busy    <= 1'b1;
               end
            end

            RUN: begin
               if (toggle) begin
                  cnt   <= '0;
                  level <= ~level;
                  leg_p <= ~level;
                  leg_n <= level;
               end

               if (!i_ena) begin
                  // Stop at once if the output is (or is about to be) low;
                  // otherwise finish the high phase that is, or is about
                  // to be, on the wire.
                  if (toggle == level) begin
                     state   <= IDLE;
                     level   <= IDLE_LEVEL;
                     cnt     <= '0;
                     leg_p   <= IDLE_LEVEL;
                     leg_n   <= ~IDLE_LEVEL;
                     running <= 1'b0;
                     busy    <= 1'b0;
                  end else begin
                     state   <= STOP;
                     running <= 1'b0;
                  end
               end else if (self_stop) begin
                  state   <= IDLE;
                  running <= 1'b0;
                  busy    <= 1'b0;
               end
            end

            STOP: begin
               if (toggle) begin
                  state   <= IDLE;
                  level   <= IDLE_LEVEL;
                  cnt     <= '0;
                  leg_p   <= IDLE_LEVEL;
                  leg_n   <= ~IDLE_LEVEL;
                  busy    <= 1'b0;
               end
            end

            default: begin
               state   <= IDLE;
               level   <= IDLE_LEVEL;
               cnt     <= '0;
               leg_p   <= IDLE_LEVEL;
               leg_n   <= ~IDLE_LEVEL;
               running <= 1'b0;
               busy    <= 1'b0;
            end
         endcase
      end
   end

   assign o_running = running;
   assign o_busy    = busy;

   ogdsbuf_tech u_obuf (
      .i_clk_p (leg_p),
      .i_clk_n (leg_n),
      .o_pad_p (o_clk_p),
      .o_pad_n (o_clk_n)
   );

endmodule : ogdsclk_fwd

`default_nettype wire

// File: tb/tb_ogdsclk_fwd.sv
// ============================================================================
// Module   : tb_ogdsclk_fwd
// Purpose  : Self-checking bench for ogdsclk_fwd. A reference model describes
//            the forwarded clock by elapsed time since start and half-period
//            length; directed and random steps are checked every cycle.
// Config   : CLKFWD_BURST_EN - enables i_burst and the burst scenarios.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ogdsclk_fwd;

   localparam int DW = 8;
`ifdef CLKFWD_BURST_EN
   localparam int BW = 16;
   logic [BW-1:0] burst;
`endif

   logic          clk = 1'b0;
   logic          rst;
   logic          ena;
   logic [DW-1:0] div;
   logic          clk_p;
   logic          clk_n;
   logic          running;
   logic          busy;

   int tests = 0;
   int fails = 0;

   // Reference model: active/stopping flags, cycles since start, half-period.
   bit m_act   = 1'b0;
   bit m_stop  = 1'b0;
   bit m_armed = 1'b1;
   int m_t     = 0;
   int m_h     = 1;
   int m_pulses = 0;
   int m_lim   = 0;

   always #5 clk = ~clk;

   ogdsclk_fwd #(
      .DIV_WIDTH (DW)
`ifdef CLKFWD_BURST_EN
      ,
      .BURST_WIDTH (BW)
`endif
   ) dut (
      .i_clk     (clk),
      .i_rst     (rst),
      .i_ena     (ena),
      .i_div     (div),
`ifdef CLKFWD_BURST_EN
      .i_burst   (burst),
`endif
      .o_clk_p   (clk_p),
      .o_clk_n   (clk_n),
      .o_running (running),
      .o_busy    (busy)
   );

   function automatic bit phase_hi(int t, int h);
      return ((t / h) % 2) == 0;
   endfunction

   function automatic int cur_burst();
`ifdef CLKFWD_BURST_EN
      return int'(burst);
`else
      return 0;
`endif
   endfunction

   task automatic check(string tag, logic obs, logic exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%b expected=%b t=%0t", tag, obs, exp, $time);
      end
   endtask

   task automatic check_int(string tag, int obs, int exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0d expected=%0d t=%0t", tag, obs, exp, $time);
      end
   endtask

   // Advance the model by one i_clk edge using the inputs sampled there.
   task automatic model_edge();
      bit self_term = 1'b0;
      bit was_hi;
      bit now_hi;
      if (rst) begin
         m_act   = 1'b0;
         m_stop  = 1'b0;
         m_armed = 1'b1;
         return;
      end
      if (!m_act) begin
         if (ena && m_armed) begin
            m_act    = 1'b1;
            m_stop   = 1'b0;
            m_t      = 0;
            m_h      = int'(div) + 1;
            m_pulses = 0;
            m_lim    = cur_burst();
         end
      end else begin
         was_hi = phase_hi(m_t, m_h);
         m_t++;
         now_hi = phase_hi(m_t, m_h);
         if (was_hi && !now_hi) m_pulses++;
         if (m_stop) begin
            if (!now_hi) m_act = 1'b0;
         end else if (!ena) begin
            // Finish a high phase in progress or just beginning; else stop.
            if (now_hi) m_stop = 1'b1;
            else        m_act  = 1'b0;
         end else if (m_lim != 0 && was_hi && !now_hi && m_pulses == m_lim) begin
            m_act     = 1'b0;
            self_term = 1'b1;
         end
      end
      if (!ena)           m_armed = 1'b1;
      else if (self_term) m_armed = 1'b0;
   endtask

   function automatic bit exp_p();
      return m_act && phase_hi(m_t, m_h);
   endfunction

   // One cycle: edge, model update, then compare away from the edge.
   task automatic tick();
      @(posedge clk);
      model_edge();
      #1;
      check("clk_p",   clk_p,   exp_p());
      check("clk_n",   clk_n,   ~exp_p());
      check("running", running, m_act && !m_stop);
      check("busy",    busy,    m_act);
   endtask

   task automatic ticks(int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic wait_idle(string tag);
      int guard = 0;
      while (busy && guard < 600) begin
         tick();
         guard++;
      end
      check(tag, busy, 1'b0);
   endtask

   // Cycles between two successive rising edges of the DUT positive leg.
   task automatic measure_period(output int per);
      int   first = -1;
      logic prev  = clk_p;
      per = -1;
      for (int c = 0; c < 200 && per < 0; c++) begin
         tick();
         if (clk_p && !prev) begin
            if (first < 0) first = c;
            else           per = c - first;
         end
         prev = clk_p;
      end
   endtask

   initial begin
      int per;
      int guard;
      int pulses;
      logic prev;

      rst = 1'b1;
      ena = 1'b0;
      div = '0;
`ifdef CLKFWD_BURST_EN
      burst = '0;
`endif
      ticks(3);
      check("rst_p",    clk_p,   1'b0);
      check("rst_n",    clk_n,   1'b1);
      check("rst_run",  running, 1'b0);
      check("rst_busy", busy,    1'b0);

      // Divide-by-2: high one cycle after enable, then alternating.
      rst = 1'b0;
      ena = 1'b1;
      div = 8'd0;
      tick();
      check("div0_first_hi", clk_p,   1'b1);
      check("div0_running",  running, 1'b1);
      tick();
      check("div0_lo", clk_p, 1'b0);
      tick();
      check("div0_hi", clk_p, 1'b1);
      ticks(5);
      ena = 1'b0;
      wait_idle("div0_stop");

      // H=3: drop enable in the 2nd high cycle; high must last 3 cycles.
      div = 8'd2;
      ena = 1'b1;
      tick();
      guard = 0;
      while (!(m_act && m_t >= 12 && (m_t % 6) == 1) && guard < 100) begin
         tick();
         guard++;
      end
      check_int("h3_reach", guard < 100 ? 1 : 0, 1);
      ena = 1'b0;
      tick();
      check("h3_stop_hi",   clk_p,   1'b1);
      check("h3_stop_run",  running, 1'b0);
      check("h3_stop_busy", busy,    1'b1);
      tick();
      check("h3_idle_p",    clk_p,   1'b0);
      check("h3_idle_busy", busy,    1'b0);

      // H=4: drop enable in the low half, then restart after one cycle.
      div = 8'd3;
      ena = 1'b1;
      tick();
      guard = 0;
      while (!(m_act && (m_t % 8) == 5) && guard < 100) begin
         tick();
         guard++;
      end
      ena = 1'b0;
      tick();
      check("lo_drop_busy", busy,  1'b0);
      check("lo_drop_p",    clk_p, 1'b0);
      ena = 1'b1;
      tick();
      check("restart_hi", clk_p, 1'b1);
      ena = 1'b0;
      wait_idle("h4_stop");

      // Divider changes while running are ignored until the next start.
      div = 8'd1;
      ena = 1'b1;
      tick();
      div = 8'd5;
      measure_period(per);
      check_int("period_div1", per, 4);
      ena = 1'b0;
      wait_idle("div1_stop");
      ena = 1'b1;
      measure_period(per);
      check_int("period_div5", per, 12);

      // Reset while high.
      guard = 0;
      while (!clk_p && guard < 20) begin
         tick();
         guard++;
      end
      rst = 1'b1;
      tick();
      check("mid_rst_p",    clk_p, 1'b0);
      check("mid_rst_n",    clk_n, 1'b1);
      check("mid_rst_busy", busy,  1'b0);
      rst = 1'b0;
      ena = 1'b0;
      tick();

      // Randomised enable/divider/reset traffic against the model.
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 7) == 0) ena = ~ena;
         if (!busy) div = DW'($urandom_range(0, 6));
         rst = ($urandom_range(0, 99) == 0);
         tick();
      end
      rst = 1'b0;

      // Largest divider: half-period of 2^DW cycles.
      ena = 1'b0;
      wait_idle("rand_stop");
      div = '1;
      ena = 1'b1;
      ticks(530);
      ena = 1'b0;
      wait_idle("max_div_stop");

`ifdef CLKFWD_BURST_EN
      // Three pulses of two cycles, then self-stop with enable still high.
      burst = 16'd3;
      div   = 8'd1;
      ena   = 1'b1;
      pulses = 0;
      prev   = clk_p;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (clk_p && !prev) pulses++;
         prev = clk_p;
      end
      check_int("burst_pulses", pulses, 3);
      check("burst_done", busy, 1'b0);
      ticks(5);
      check("burst_no_restart", busy, 1'b0);
      ena = 1'b0;
      tick();
      burst = 16'd0;
      ena   = 1'b1;
      tick();
      check("burst_rearm", clk_p, 1'b1);
      ticks(40);
      check("burst_unlimited", busy, 1'b1);
      ena = 1'b0;
      wait_idle("burst_stop");
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule : tb_ogdsclk_fwd

`default_nettype wire
